// File: rtl/stream_demux_n.sv
// stream_demux_n: N-way registered stream demux with one holding register per output channel.
// Define DEMUX_ERR_EN to add the sticky out-of-range-select flag `err`.
module stream_demux_n #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N*W-1:0]   out_data,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready
`ifdef DEMUX_ERR_EN
  ,
  output logic             err
`endif
);

  if (SEL_W != $clog2(N)) begin : g_bad_sel_w
    $error("stream_demux_n: SEL_W must equal $clog2(N)");
  end

  logic [N-1:0] vq;
  logic [W-1:0] dq [N];
  logic [N-1:0] sel_hit;
  logic [N-1:0] wr;
  logic         sel_ok;

  // One-hot decode of in_sel; an out-of-range select hits no channel.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < N; i++) begin
      sel_hit[i] = (32'(in_sel) == 32'(i));
    end
  end

  // A channel only blocks when it is full and its consumer is not taking the word.
  always_comb begin
    sel_ok   = |sel_hit;
    in_ready = ~|(sel_hit & vq & ~out_ready);
    wr       = {N{in_valid & in_ready}} & sel_hit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vq <= '0;
      for (int i = 0; i < N; i++) begin
        dq[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr[i]) begin
          vq[i] <= 1'b1;
          dq[i] <= in_data;
        end else if (out_ready[i]) begin
          vq[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = vq;

  for (genvar g = 0; g < N; g++) begin : g_out
    assign out_data[g*W +: W] = dq[g];
  end

`ifdef DEMUX_ERR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (in_valid & in_ready & ~sel_ok) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: directed scenarios plus random traffic against a per-channel buffer model.
// A second N=3 instance exercises the out-of-range select path.
module tb_stream_demux_n;
  localparam int W     = 8;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [W-1:0]     in_data;
  logic [SEL_W-1:0] in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   out_data;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;

  logic [7:0]  d3;
  logic [1:0]  s3;
  logic        v3;
  logic        r3;
  logic [23:0] od3;
  logic [2:0]  ov3;
  logic [2:0]  or3;
`ifdef DEMUX_ERR_EN
  logic err4;
  logic err3;
`endif

  always #5 clock = ~clock;

  stream_demux_n #(.W(W), .N(N), .SEL_W(SEL_W)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef DEMUX_ERR_EN
    , .err(err4)
`endif
  );

  stream_demux_n #(.W(8), .N(3), .SEL_W(2)) dut3 (
    .clock(clock), .reset(reset),
    .in_data(d3), .in_sel(s3), .in_valid(v3), .in_ready(r3),
    .out_data(od3), .out_valid(ov3), .out_ready(or3)
`ifdef DEMUX_ERR_EN
    , .err(err3)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference: each channel is a one-word buffer (full flag + word).
  bit           mv [N];
  logic [W-1:0] md [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready(input int sel, input logic [N-1:0] ordy);
    if (sel >= N) return 1'b1;
    return !mv[sel] || ordy[sel];
  endfunction

  task automatic check_state(input string tag);
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    for (int i = 0; i < N; i++) begin
      ev[i]         = mv[i];
      ed[i*W +: W]  = md[i];
    end
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, "_out_data"},  64'(out_data),  64'(ed));
  endtask

  // One clock: drive at negedge, check comb ready and registered outputs, then advance the model.
  task automatic cycle(input bit v, input int sel, input logic [W-1:0] d,
                       input logic [N-1:0] ordy, input string tag, output bit acc);
    bit          er;
    logic [31:0] su;
    @(negedge clock);
    su        = sel;
    in_valid  = v;
    in_sel    = su[SEL_W-1:0];
    in_data   = d;
    out_ready = ordy;
    #1;
    er = model_ready(sel, ordy);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(er));
    check_state(tag);
    acc = v && er;
    @(posedge clock);
    for (int i = 0; i < N; i++) begin
      if (acc && sel == i) begin
        mv[i] = 1'b1;
        md[i] = d;
      end else if (ordy[i]) begin
        mv[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = '0;
    v3        = 1'b0;
    repeat (n) @(posedge clock);
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          a;
    bit          pend_v;
    int          pend_s;
    logic [W-1:0] pend_d;
    logic [N-1:0] ordy;

    reset = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    v3 = 1'b0; s3 = '0; d3 = '0; or3 = '0;

    // 1: reset state
    do_reset(2);
    for (int s = 0; s < N; s++) begin
      in_sel = SEL_W'(s);
      #1;
      chk($sformatf("t1_in_ready_sel%0d", s), 64'(in_ready), 64'd1);
    end
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    chk("t1_out_data",  64'(out_data),  64'd0);
`ifdef DEMUX_ERR_EN
    chk("t1_err", 64'(err4), 64'd0);
`endif

    // 2: fill channel 2, then it blocks while the other channels still accept
    cycle(1'b1, 2, 8'hA5, 4'b0000, "t2_load", a);
    #1;
    chk("t2_valid_0100", 64'(out_valid), 64'h4);
    chk("t2_data_ch2",   64'(out_data[23:16]), 64'hA5);
    chk("t2_ready_sel2", 64'(in_ready), 64'd0);
    cycle(1'b1, 2, 8'h5A, 4'b0000, "t2_blocked", a);
    chk("t2_blocked_acc", 64'(a), 64'd0);
    cycle(1'b1, 0, 8'h11, 4'b0000, "t2_sel0", a);
    cycle(1'b1, 1, 8'h22, 4'b0000, "t2_sel1", a);
    cycle(1'b1, 3, 8'h33, 4'b0000, "t2_sel3", a);

    // 3: channel 1 streams one word per cycle with its consumer always ready
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, 1, 8'(k), 4'b0010, $sformatf("t3_w%0d", k), a);
      #1;
      chk($sformatf("t3_data_w%0d", k), 64'(out_data[15:8]), 64'(k));
      chk($sformatf("t3_vld_w%0d", k),  64'(out_valid[1]),   64'd1);
    end
    cycle(1'b0, 0, 8'h00, 4'b0010, "t3_drain", a);

    // 4: simultaneous drain and refill on channel 3
    cycle(1'b1, 3, 8'h3C, 4'b1000, "t4_swap", a);
    chk("t4_acc", 64'(a), 64'd1);
    #1;
    chk("t4_vld3",  64'(out_valid[3]),      64'd1);
    chk("t4_data3", 64'(out_data[31:24]),   64'h3C);
    cycle(1'b0, 0, 8'h00, 4'b1111, "t4_drain_all", a);

    // 5: N=3 instance, out-of-range select is consumed and dropped
    @(negedge clock);
    s3 = 2'd3; d3 = 8'h77; v3 = 1'b1; or3 = 3'b000;
    #1;
    chk("t5_ready", 64'(r3), 64'd1);
    @(posedge clock);
    #1;
    chk("t5_no_valid", 64'(ov3), 64'd0);
`ifdef DEMUX_ERR_EN
    chk("t5_err_set", 64'(err3), 64'd1);
`endif
    @(negedge clock);
    v3 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("t5_still_no_valid", 64'(ov3), 64'd0);
`ifdef DEMUX_ERR_EN
    chk("t5_err_sticky", 64'(err3), 64'd1);
`endif

    // 6: reset with channels 0 and 2 full and stalled
    cycle(1'b1, 0, 8'hC0, 4'b0000, "t6_fill0", a);
    cycle(1'b1, 2, 8'hC2, 4'b0000, "t6_fill2", a);
    cycle(1'b0, 0, 8'h00, 4'b0000, "t6_hold", a);
    do_reset(1);
    #1;
    chk("t6_valid_cleared", 64'(out_valid), 64'd0);
`ifdef DEMUX_ERR_EN
    chk("t6_err3_cleared", 64'(err3), 64'd0);
`endif
    cycle(1'b1, 2, 8'h99, 4'b0000, "t6_post", a);
    #1;
    chk("t6_post_valid", 64'(out_valid), 64'h4);
    chk("t6_post_data",  64'(out_data[23:16]), 64'h99);
    cycle(1'b0, 0, 8'h00, 4'b1111, "t6_drain", a);

    // Random traffic; a stalled word is held stable until accepted
    pend_v = 1'b0; pend_s = 0; pend_d = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend_v) begin
        pend_v = ($urandom_range(0, 3) != 0);
        pend_s = int'($urandom_range(0, N-1));
        pend_d = W'($urandom);
      end
      ordy = N'($urandom);
      cycle(pend_v, pend_s, pend_d, ordy, $sformatf("rnd%0d", c), a);
      if (a) pend_v = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
